// File: rtl/uart_loopback_slave.sv
// uart_loopback_slave: UART register map (DATA/COUNT/STATUS) whose TX writes loop back into an RX FIFO.
module uart_loopback_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hc0000000,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_BITS = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_en,
    input  logic                  i_rnw,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_next;

    logic [CW-1:0] wait_cnt;
    logic [1:0] off_q;
    logic rnw_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CNTW-1:0] count;
    logic overflow, underflow;
    logic [DATA_WIDTH-1:0] rdata;
    logic hit, accept, commit, empty, full, is_data, is_status;
    logic push, pop, flush, set_ov, set_ud;
    logic unused_ok;

    assign hit = i_address[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign accept = state == IDLE && i_en && hit;
    assign commit = state == RESP;
    assign empty = count == '0;
    assign full = count == CNTW'(FIFO_DEPTH);
    assign is_data = off_q == 2'd0;
    assign is_status = off_q == 2'd2;
    assign push = commit && !rnw_q && is_data && !full;
    assign pop = commit && rnw_q && is_data && !empty;
    assign set_ov = commit && !rnw_q && is_data && full;
    assign set_ud = commit && rnw_q && is_data && empty;
    assign flush = commit && !rnw_q && is_status && data_q[0];
    assign unused_ok = &{1'b0, i_address[1:0], data_q};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = accept ? (READ_LATENCY > 1 ? WAIT : RESP) : IDLE;
            WAIT: state_next = wait_cnt == CW'(READ_LATENCY - 2) ? RESP : WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_cnt <= '0;
            off_q <= '0;
            rnw_q <= 1'b0;
            data_q <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wait_cnt <= state == WAIT ? wait_cnt + CW'(1) : '0;
            if (accept) begin
                off_q <= i_address[3:2];
                rnw_q <= i_rnw;
                data_q <= i_data;
            end
            rd_ptr <= flush ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= flush ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
            count <= flush ? '0 : push ? count + CNTW'(1) : pop ? count - CNTW'(1) : count;
            // W1C and flush in one STATUS write both apply
            overflow <= (overflow && !(commit && !rnw_q && is_status && data_q[2])) || set_ov;
            underflow <= (underflow && !(commit && !rnw_q && is_status && data_q[3])) || set_ud;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_q[DATA_BITS-1:0];
    end

    always_comb begin
        rdata = '0;
        if (is_data) rdata[DATA_BITS-1:0] = empty ? '0 : mem[rd_ptr];
        else if (off_q == 2'd1) rdata[CNTW-1:0] = count;
        else if (is_status) rdata[3:0] = {underflow, overflow, full, empty};
    end

    assign o_busy = state != IDLE;
    assign o_data_valid = commit && rnw_q;
    assign o_data = o_data_valid ? rdata : '0;
endmodule

// File: tb/tb_uart_loopback_slave.sv
// tb_uart_loopback_slave: directed checks on a latency-1 and a latency-3 instance.
module tb_uart_loopback_slave;
    localparam logic [31:0] B = 32'hc0000000;

    logic clk = 1'b0;
    logic rst1, rst3, en1, en3, rnw1, rnw3;
    logic [31:0] a1, a3, wd1, wd3, od1, od3;
    logic v1, v3, busy1, busy3;
    int checks = 0;
    int errors = 0;
    logic [31:0] rv;
    logic vv;

    always #5 clk = ~clk;

    uart_loopback_slave #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .n_rst(rst1), .i_en(en1), .i_rnw(rnw1), .i_address(a1),
        .i_data(wd1), .o_data(od1), .o_data_valid(v1), .o_busy(busy1)
    );

    uart_loopback_slave #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .n_rst(rst3), .i_en(en3), .i_rnw(rnw3), .i_address(a3),
        .i_data(wd3), .o_data(od3), .o_data_valid(v3), .o_busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Drives one access, returns outputs sampled in the response cycle.
    task automatic access(input bit d3, input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic vld);
        int lat;
        lat = d3 ? 3 : 1;
        @(posedge clk); #1;
        if (d3) begin en3 = 1; rnw3 = rnw; a3 = addr; wd3 = data; end
        else begin en1 = 1; rnw1 = rnw; a1 = addr; wd1 = data; end
        @(posedge clk); #1;
        en1 = 0; en3 = 0;
        repeat (lat - 1) begin @(posedge clk); #1; end
        rdata = d3 ? od3 : od1;
        vld = d3 ? v3 : v1;
        @(posedge clk); #1;
    endtask

    task automatic rd(input bit d3, input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        logic v;
        access(d3, 1'b1, addr, 32'h0, r, v);
        chk({tag, "_valid"}, {31'h0, v}, 32'h1);
        chk(tag, r, exp);
    endtask

    task automatic wr(input bit d3, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        logic v;
        access(d3, 1'b0, addr, data, r, v);
        chk("wr_valid", {31'h0, v}, 32'h0);
    endtask

    initial begin
        rst1 = 0; rst3 = 0; en1 = 0; en3 = 0; rnw1 = 0; rnw3 = 0;
        a1 = 0; a3 = 0; wd1 = 0; wd3 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy1}, 32'h0);
        chk("rst_valid", {31'h0, v1}, 32'h0);
        chk("rst_data", od1, 32'h0);
        rst1 = 1; rst3 = 1;

        rd(0, B + 8, 32'h1, "status_reset");
        rd(0, B + 4, 32'h0, "count_reset");
        wr(0, B, 32'h41);
        wr(0, B, 32'h42);
        wr(0, B, 32'h43);
        rd(0, B + 4, 32'h3, "count3");
        rd(0, B + 6, 32'h3, "count3_lowbits");
        rd(0, B, 32'h41, "pop0");
        rd(0, B, 32'h42, "pop1");
        rd(0, B, 32'h43, "pop2");
        rd(0, B + 8, 32'h1, "status_empty");

        for (int i = 0; i < 9; i++) wr(0, B, 32'h10 + i);
        rd(0, B + 8, 32'h6, "status_full_ov");
        rd(0, B + 4, 32'h8, "count_full");
        wr(0, B + 8, 32'h4);
        rd(0, B + 8, 32'h2, "status_ov_clr");
        wr(0, B + 8, 32'h1);
        rd(0, B + 8, 32'h1, "status_flush");
        rd(0, B + 4, 32'h0, "count_flush");

        rd(0, B, 32'h0, "pop_empty");
        rd(0, B + 8, 32'h9, "status_ud");
        wr(0, B + 8, 32'h9);
        rd(0, B + 8, 32'h1, "status_ud_clr");
        wr(0, B, 32'hffffff5a);
        rd(0, B, 32'h5a, "pop_trunc");
        wr(0, B + 12, 32'hffffffff);
        rd(0, B + 12, 32'h0, "reserved");

        // i_en held high on the latency-3 instance: one access every 4 cycles
        @(posedge clk); #1;
        en3 = 1; rnw3 = 1; a3 = B + 8;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("held_busy%0d", k), {31'h0, busy3}, {31'h0, (k % 4) != 0});
            chk($sformatf("held_valid%0d", k), {31'h0, v3}, {31'h0, (k % 4) == 3});
            if (k % 4 == 3) chk($sformatf("held_data%0d", k), od3, 32'h1);
        end
        en3 = 0;

        @(posedge clk); #1;
        en3 = 1; rnw3 = 1; a3 = 32'hc0001000;
        @(posedge clk); #1;
        en3 = 0;
        for (int k = 0; k < 4; k++) begin
            chk("miss_busy", {31'h0, busy3}, 32'h0);
            chk("miss_valid", {31'h0, v3}, 32'h0);
            @(posedge clk); #1;
        end

        wr(1, B, 32'h11);
        wr(1, B, 32'h22);
        rd(1, B + 4, 32'h2, "l3_count2");
        @(posedge clk); #1;
        en3 = 1; rnw3 = 1; a3 = B;
        @(posedge clk); #1;
        en3 = 0;
        chk("pre_rst_busy", {31'h0, busy3}, 32'h1);
        rst3 = 0;
        #1;
        chk("mid_rst_busy", {31'h0, busy3}, 32'h0);
        chk("mid_rst_valid", {31'h0, v3}, 32'h0);
        chk("mid_rst_data", od3, 32'h0);
        @(posedge clk); #1;
        rst3 = 1;
        rd(1, B + 4, 32'h0, "post_rst_count");
        rd(1, B + 8, 32'h1, "post_rst_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
